// File: rtl/float_div_seq.sv
// float_div_seq: bit-serial restoring divider for the {sign, exp, man} float
// format. Operands are aligned to fixed point (man << exp) and divided as
// unsigned magnitudes; quotient and remainder come out as integers.
// Optional build macro: FLOAT_DIV_ROUND_EN adds a rounding step after the
// divide (round half up, saturating); when undefined the quotient truncates.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; operands captured on accepted start
// ALIGN  | align operands, seed divider, detect zero divisor
// DIVIDE | one restoring step per cycle, FX_W cycles
// ROUND  | (FLOAT_DIV_ROUND_EN only) round quotient from remainder
// DONE   | results valid, done pulses for one cycle

module float_div_seq #(
    parameter  int EXP_W = 3,
    parameter  int MAN_W = 4,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int FX_W  = MAN_W + (1 << EXP_W) - 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    num,
    input  logic [W-1:0]    den,
    output logic            busy,
    output logic            done,
    output logic [FX_W-1:0] quotient,
    output logic [FX_W-1:0] remainder,
    output logic            q_sign,
    output logic            div_zero
);

    localparam int CNT_W = $clog2(FX_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_DIVIDE = 3'd2,
`ifdef FLOAT_DIV_ROUND_EN
        S_ROUND  = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t state, next_state;

    logic [W-1:0]     num_r, den_r;
    logic [FX_W-1:0]  fd_r;
    logic [FX_W-1:0]  rem_r;
    logic [FX_W-1:0]  q_r;
    logic [CNT_W-1:0] count_r;
    logic             sign_r;

    logic [FX_W-1:0]  fn_a, fd_a;
    logic [FX_W:0]    shifted;
    logic             trial_ge;
    logic [FX_W-1:0]  rem_step, q_step;
`ifdef FLOAT_DIV_ROUND_EN
    logic             round_up;
    logic [FX_W-1:0]  q_round;
`endif

    // Align captured operands to the shared fixed-point scale
    always_comb begin
        fn_a = FX_W'(num_r[MAN_W-1:0]) << num_r[W-2:MAN_W];
        fd_a = FX_W'(den_r[MAN_W-1:0]) << den_r[W-2:MAN_W];
    end

    // One restoring step: shift {rem,q} left, keep the trial subtraction if it fits
    always_comb begin
        shifted  = {rem_r, q_r[FX_W-1]};
        trial_ge = (shifted >= {1'b0, fd_r});
        rem_step = trial_ge ? FX_W'(shifted - {1'b0, fd_r}) : FX_W'(shifted);
        q_step   = {q_r[FX_W-2:0], trial_ge};
    end

`ifdef FLOAT_DIV_ROUND_EN
    // Round half up on the final remainder, saturating at all ones
    always_comb begin
        round_up = ({rem_r, 1'b0} >= {1'b0, fd_r});
        q_round  = (round_up && (q_r != '1)) ? q_r + FX_W'(1) : q_r;
    end
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_ALIGN;
            S_ALIGN:  next_state = (fd_a == '0) ? S_DONE : S_DIVIDE;
            S_DIVIDE: begin
                if (count_r == '0) begin
`ifdef FLOAT_DIV_ROUND_EN
                    next_state = S_ROUND;
`else
                    next_state = S_DONE;
`endif
                end
            end
`ifdef FLOAT_DIV_ROUND_EN
            S_ROUND:  next_state = S_DONE;
`endif
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_ALIGN, S_DIVIDE: busy = 1'b1;
`ifdef FLOAT_DIV_ROUND_EN
            S_ROUND:           busy = 1'b1;
`endif
            S_DONE:            done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, divider registers and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            num_r     <= '0;
            den_r     <= '0;
            fd_r      <= '0;
            rem_r     <= '0;
            q_r       <= '0;
            count_r   <= '0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            q_sign    <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_r <= num;
                        den_r <= den;
                    end
                end
                S_ALIGN: begin
                    rem_r   <= '0;
                    q_r     <= fn_a;
                    fd_r    <= fd_a;
                    count_r <= CNT_W'(FX_W - 1);
                    sign_r  <= num_r[W-1] ^ den_r[W-1];
                    if (fd_a == '0) begin
                        quotient  <= '1;
                        remainder <= fn_a;
                        q_sign    <= num_r[W-1] ^ den_r[W-1];
                        div_zero  <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    rem_r   <= rem_step;
                    q_r     <= q_step;
                    count_r <= count_r - CNT_W'(1);
`ifndef FLOAT_DIV_ROUND_EN
                    if (count_r == '0) begin
                        quotient  <= q_step;
                        remainder <= rem_step;
                        q_sign    <= sign_r;
                        div_zero  <= 1'b0;
                    end
`endif
                end
`ifdef FLOAT_DIV_ROUND_EN
                S_ROUND: begin
                    quotient  <= q_round;
                    remainder <= rem_r;
                    q_sign    <= sign_r;
                    div_zero  <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_div_seq.sv
// tb_float_div_seq: directed and random checks of float_div_seq against an
// arithmetic reference model (integer divide of the aligned operands).

module tb_float_div_seq;

    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int FX_W  = MAN_W + (1 << EXP_W) - 1;
    localparam int ALL1  = (1 << FX_W) - 1;
`ifdef FLOAT_DIV_ROUND_EN
    localparam int LAT   = FX_W + 3;
`else
    localparam int LAT   = FX_W + 2;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    num   = '0;
    logic [W-1:0]    den   = '0;
    logic            busy, done, q_sign, div_zero;
    logic [FX_W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    int   exp_q, exp_r, exp_lat;
    logic exp_s, exp_z;

    float_div_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .num       (num),
        .den       (den),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .q_sign    (q_sign),
        .div_zero  (div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: value = man * 2^exp, magnitudes divided with integer ops
    task automatic model(input logic [W-1:0] n, input logic [W-1:0] d);
        int fn, fd;
        fn = (int'(n) % (1 << MAN_W)) * (1 << ((int'(n) >> MAN_W) % (1 << EXP_W)));
        fd = (int'(d) % (1 << MAN_W)) * (1 << ((int'(d) >> MAN_W) % (1 << EXP_W)));
        exp_s = n[W-1] ^ d[W-1];
        if (fd == 0) begin
            exp_z   = 1'b1;
            exp_q   = ALL1;
            exp_r   = fn;
            exp_lat = 2;
        end else begin
            exp_z   = 1'b0;
            exp_q   = fn / fd;
            exp_r   = fn % fd;
            exp_lat = LAT;
`ifdef FLOAT_DIV_ROUND_EN
            if (2 * exp_r >= fd && exp_q < ALL1) exp_q = exp_q + 1;
`endif
        end
    endtask

    // Cycle counter starts at 1 just after the edge that sampled start
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " quotient"},  32'(quotient),  exp_q);
        chk({tag, " remainder"}, 32'(remainder), exp_r);
        chk({tag, " q_sign"},    32'(q_sign),    32'(exp_s));
        chk({tag, " div_zero"},  32'(div_zero),  32'(exp_z));
    endtask

    // Full operation; poke=1 fires a stray start with other operands mid-flight
    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input bit poke, input string tag);
        int lat;
        model(n, d);
        @(negedge clock);
        num = n; den = d; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        if (poke) begin
            repeat (2) @(posedge clock);
            @(negedge clock);
            num = 8'h48; den = 8'h50; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            num = 8'hFF; den = 8'h11;
            wait_done(lat);
            lat = lat + 3;
        end else begin
            num = ~n; den = ~d;
            wait_done(lat);
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check_outputs(tag);
        @(posedge clock); #1;
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [W-1:0] rn, rd;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst quotient", 32'(quotient), 32'd0);
        chk("rst remainder", 32'(remainder), 32'd0);
        chk("rst q_sign", 32'(q_sign), 32'd0);
        chk("rst div_zero", 32'(div_zero), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed cases
        run_op(8'h48, 8'h28, 1'b0, "128/32");
        chk("128/32 const_q", 32'(quotient), 32'd4);
        run_op(8'h3B, 8'h23, 1'b0, "88/12");
        chk("88/12 const_r", 32'(remainder), 32'd4);
        run_op(8'h3B, 8'h2D, 1'b0, "88/52");
`ifdef FLOAT_DIV_ROUND_EN
        chk("88/52 const_q", 32'(quotient), 32'd2);
`else
        chk("88/52 const_q", 32'(quotient), 32'd1);
`endif
        chk("88/52 const_r", 32'(remainder), 32'd36);
        run_op(8'hC8, 8'h28, 1'b0, "neg_num");
        chk("neg_num const_sign", 32'(q_sign), 32'd1);
        run_op(8'hC8, 8'hA8, 1'b0, "neg_both");
        run_op(8'h48, 8'h50, 1'b0, "div0");
        chk("div0 const_q", 32'(quotient), 32'h7FF);
        chk("div0 const_r", 32'(remainder), 32'd128);
        run_op(8'h80, 8'h28, 1'b0, "neg_zero_num");
        run_op(8'h00, 8'h3B, 1'b0, "zero_num");
        run_op(8'h7F, 8'h01, 1'b0, "max_over_1");
        run_op(8'h01, 8'h7F, 1'b0, "min_over_max");

        // Output hold after done while inputs wander
        @(negedge clock);
        num = 8'h5A; den = 8'hA5;
        repeat (5) @(posedge clock);
        #1;
        check_outputs("hold");

        // Start while busy is ignored
        run_op(8'h3B, 8'h23, 1'b1, "busy_start");

        // Back-to-back: start held through DONE is only taken in the next IDLE
        model(8'h48, 8'h28);
        @(negedge clock);
        num = 8'h48; den = 8'h28; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(lat);
        chk("b2b first latency", 32'(lat), 32'(exp_lat));
        num = 8'h3B; den = 8'h23; start = 1'b1;
        @(posedge clock); #1;
        chk("b2b idle_not_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        start = 1'b0;
        chk("b2b accepted", 32'(busy), 32'd1);
        model(8'h3B, 8'h23);
        wait_done(lat);
        chk("b2b second latency", 32'(lat), 32'(exp_lat));
        check_outputs("b2b");
        @(posedge clock); #1;

        // Reset in the middle of a divide
        @(negedge clock);
        num = 8'h3B; den = 8'h2D; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst quotient", 32'(quotient), 32'd0);
        chk("midrst remainder", 32'(remainder), 32'd0);
        chk("midrst q_sign", 32'(q_sign), 32'd0);
        chk("midrst div_zero", 32'(div_zero), 32'd0);
        done_seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        chk("midrst abandoned", 32'(done_seen), 32'd0);
        run_op(8'h48, 8'h28, 1'b0, "after_rst");

        // Random operands
        for (int i = 0; i < 40; i++) begin
            rn = W'($urandom_range(0, (1 << W) - 1));
            rd = W'($urandom_range(0, (1 << W) - 1));
            run_op(rn, rd, 1'b0, $sformatf("rand%0d %02h/%02h", i, rn, rd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_div_seq.md
Name: float_div_seq

Overview:
- Parametrised sequential divider for the team's small floating-point format {sign, exp[EXP_W], man[MAN_W]}.
- Successor to the fixed 8-bit divide FSM. Adds generic exponent/mantissa widths, a start/busy/done handshake, sign handling, divide-by-zero detection and a bit-serial restoring divide with fixed latency.
- Output is fixed point: integer quotient plus remainder. It sits between operand registers and downstream fixed-point datapath logic.

Parameters:
- EXP_W, 3: exponent field width.
- MAN_W, 4: mantissa field width. There is no hidden bit; the mantissa is an unsigned integer.
- Derived, not overridable:
  - W = 1+EXP_W+MAN_W
  - FX_W = MAN_W + 2^EXP_W - 1

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request. Sampled only in IDLE.
- num  in  W  dividend float. Captured on accepted start.
- den  in  W  divisor float. Captured on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- quotient  out  FX_W  unsigned integer quotient magnitude.
- remainder  out  FX_W  unsigned remainder, same fixed-point scale as the aligned operands.
- q_sign  out  1  num[W-1] XOR den[W-1].
- div_zero  out  1  divisor mantissa was zero.

Behaviour:
- Reset (synchronous, active-high): the following clear to 0 in the cycle after reset is sampled. This also applies mid-operation; any in-flight divide is abandoned.
  - state -> IDLE
  - busy, done, quotient, remainder, q_sign, div_zero all -> 0
- Alignment: Fx = man << exp, zero-extended to FX_W bits; it never overflows. Both operands share the scale 2^-(2^(EXP_W-1)-1), so quotient = floor(Fn/Fd) and remainder = Fn mod Fd.
- FSM states:
  - IDLE: on start=1, capture num/den into internal regs, go to ALIGN, busy=1. start=0 stays in IDLE.
  - ALIGN (1 cycle):
    - Compute Fn and Fd; load the partial remainder with 0 and the quotient shift register with Fn. Set count=FX_W-1.
    - If Fd==0, go to DONE with div_zero=1, quotient=all ones, remainder=Fn.
    - Otherwise go to DIVIDE.
  - DIVIDE (exactly FX_W cycles):
    - Restoring step per cycle: shift {rem,q} left by 1, trial = rem - Fd.
    - If trial is non-negative: rem=trial, q LSB=1. Otherwise restore and set q LSB=0.
    - count decrements; at count==0 go to DONE.
    - The partial remainder is FX_W+1 bits internally.
  - DONE (1 cycle): register quotient, remainder, q_sign, div_zero; done=1, busy=0; return to IDLE.
- Latency: done is asserted FX_W+2 cycles after the cycle start is sampled (13 at defaults). Divide-by-zero takes 2 cycles.
- Back-to-back: start may be reasserted in the same cycle done pulses is not accepted (FSM is in DONE). It is accepted in the next IDLE cycle.
- start while busy: ignored, no effect on the operation in flight.
- Output hold: quotient, remainder, q_sign and div_zero hold their values until the next DONE or reset. num/den may change freely after capture.
- Zero dividend: Fn==0 gives quotient=0, remainder=0 after the full latency.
- Sign: magnitudes are divided. Negative zero is treated as zero, but q_sign still reflects the XOR.

Optional Feature:
- Macro: FLOAT_DIV_ROUND_EN.
- Defined:
  - Adds a ROUND state between DIVIDE and DONE, so latency becomes FX_W+3.
  - If 2*remainder >= Fd, quotient increments and saturates at all ones. remainder is reported unchanged, pre-round.
  - Divide-by-zero bypasses ROUND.
- Undefined: quotient is truncated; there is no ROUND state.

Test Plan:
- num=0x48, den=0x28 (Fn=128, Fd=32), start pulse -> done at cycle 13: quotient=4, remainder=0, q_sign=0, div_zero=0.
- num=0x3B, den=0x23 (88/12) -> quotient=7, remainder=4.
- num=0x3B, den=0x2D (88/52) -> quotient=1, remainder=36. With FLOAT_DIV_ROUND_EN: quotient=2, remainder=36, done at cycle 14.
- num=0xC8, den=0x28 -> quotient=4, q_sign=1. Then num=0xC8, den=0xA8 -> q_sign=0.
- num=0x48, den=0x50 (mantissa 0) -> done 2 cycles after start: div_zero=1, quotient=0x7FF, remainder=128.
- Assert reset at DIVIDE cycle 5, then start with 0x48/0x28 after reset -> all outputs 0 after reset; fresh result quotient=4 after 13 cycles. A start pulse while busy is ignored.
